// File: rtl/dp_sched_ctrl.sv
`default_nettype none
// dp_sched_ctrl: round-robin two-channel scheduler driving a shared multiply/complement datapath.
// Rev 1.0 - initial release.
module dp_sched_ctrl #(
   parameter int LAT   = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             res,
   input  logic             req0,
   input  logic             req1,
   input  logic [3:0]       a0,
   input  logic [3:0]       b0,
   input  logic [3:0]       a1,
   input  logic [3:0]       b1,
   input  logic             comp0,
   input  logic             comp1,
   output logic             ack0,
   output logic             ack1,
   output logic [3:0]       dp_a,
   output logic [3:0]       dp_b,
   output logic             dp_en_in,
   output logic             dp_en_out,
   output logic             dp_sw,
   input  logic [7:0]       dp_data,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [7:0]       rsp_data,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(LAT - 1);

   state_t     state, state_nx;
   logic       last_id;
   logic       op_id;
   logic       gnt_id;
   logic       any_req;
   logic [3:0] wcnt;

   assign any_req = req0 | req1;
   // Under contention the channel that did not win last time gets the grant.
   assign gnt_id  = (req0 & req1) ? ~last_id : req1;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (wcnt == 4'd0) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are registered from the transition being taken, so they line up with the new state.
   always_ff @(posedge clk) begin
      if (res) begin
         state     <= IDLE;
         last_id   <= 1'b1;
         op_id     <= 1'b0;
         wcnt      <= 4'd0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         dp_a      <= 4'd0;
         dp_b      <= 4'd0;
         dp_en_in  <= 1'b0;
         dp_en_out <= 1'b0;
         dp_sw     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= 8'd0;
         busy      <= 1'b0;
         done_cnt  <= '0;
      end else begin
         state     <= state_nx;
         busy      <= (state_nx != IDLE);
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         dp_en_in  <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  op_id    <= gnt_id;
                  last_id  <= gnt_id;
                  ack0     <= ~gnt_id;
                  ack1     <= gnt_id;
                  dp_en_in <= 1'b1;
                  dp_a     <= gnt_id ? a1 : a0;
                  dp_b     <= gnt_id ? b1 : b0;
                  dp_sw    <= gnt_id ? comp1 : comp0;
               end
            end
            ISSUE: begin
               wcnt      <= WAIT_LOAD;
               dp_en_out <= 1'b1;
            end
            WAIT: begin
               if (wcnt == 4'd0) begin
                  dp_en_out <= 1'b0;
                  rsp_data  <= dp_data;
                  rsp_id    <= op_id;
                  rsp_valid <= 1'b1;
                  done_cnt  <= done_cnt + CNT_W'(1);
               end else begin
                  wcnt <= wcnt - 4'd1;
               end
            end
            RESP: begin
               dp_a  <= 4'd0;
               dp_b  <= 4'd0;
               dp_sw <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dp_sched_ctrl.sv
`default_nettype none
// tb_dp_sched_ctrl: directed bench for dp_sched_ctrl with LAT=2 and LAT=1 instances.
// Rev 1.0
module tb_dp_sched_ctrl;

   logic       clk = 1'b0;
   logic       res;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic       comp0, comp1;

   logic       ack0, ack1, dp_en_in, dp_en_out, dp_sw, rsp_valid, rsp_id, busy;
   logic [3:0] dp_a, dp_b;
   logic [7:0] dp_data, rsp_data, done_cnt;

   logic       ack0_l1, ack1_l1, dp_en_in_l1, dp_en_out_l1, dp_sw_l1, rsp_valid_l1, rsp_id_l1, busy_l1;
   logic [3:0] dp_a_l1, dp_b_l1;
   logic [7:0] dp_data_l1, rsp_data_l1, done_cnt_l1;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   dp_sched_ctrl #(.LAT(2), .CNT_W(8)) u_dut (
      .clk(clk), .res(res), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .comp0(comp0), .comp1(comp1),
      .ack0(ack0), .ack1(ack1), .dp_a(dp_a), .dp_b(dp_b),
      .dp_en_in(dp_en_in), .dp_en_out(dp_en_out), .dp_sw(dp_sw), .dp_data(dp_data),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy), .done_cnt(done_cnt)
   );

   dp_sched_ctrl #(.LAT(1), .CNT_W(8)) u_dut_l1 (
      .clk(clk), .res(res), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .comp0(comp0), .comp1(comp1),
      .ack0(ack0_l1), .ack1(ack1_l1), .dp_a(dp_a_l1), .dp_b(dp_b_l1),
      .dp_en_in(dp_en_in_l1), .dp_en_out(dp_en_out_l1), .dp_sw(dp_sw_l1), .dp_data(dp_data_l1),
      .rsp_valid(rsp_valid_l1), .rsp_id(rsp_id_l1), .rsp_data(rsp_data_l1),
      .busy(busy_l1), .done_cnt(done_cnt_l1)
   );

   function automatic logic [7:0] dp_func(input logic [3:0] a, input logic [3:0] b, input logic sw);
      logic [7:0] p;
      p = {4'b0, a} * {4'b0, b};
      return sw ? ~p : p;
   endfunction

   // Datapath models: result appears LAT cycles after the operands are presented.
   logic [7:0] pipe0, pipe1, pipe_l1;
   always @(posedge clk) begin
      pipe0   <= dp_func(dp_a, dp_b, dp_sw);
      pipe1   <= pipe0;
      pipe_l1 <= dp_func(dp_a_l1, dp_b_l1, dp_sw_l1);
   end
   assign dp_data    = pipe1;
   assign dp_data_l1 = pipe_l1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 12 && (busy || busy_l1); i++) tick();
      nvec++;
      if (busy !== 1'b0) begin
         nerr++;
         $display("FAIL idle_timeout: busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset();
      res = 1'b1;
      tick();
      tick();
      nvec++;
      if ({ack0, ack1, dp_a, dp_b, dp_en_in, dp_en_out, dp_sw, rsp_valid, rsp_id, rsp_data, busy, done_cnt} !== 32'd0) begin
         nerr++;
         $display("FAIL reset_outputs: got %h required 0",
                  {ack0, ack1, dp_a, dp_b, dp_en_in, dp_en_out, dp_sw, rsp_valid, rsp_id, rsp_data, busy, done_cnt});
      end
      res = 1'b0;
      tick();
   endtask

   task automatic test_single();
      req0 = 1'b1; a0 = 4'd3; b0 = 4'd5; comp0 = 1'b0;
      tick();
      nvec++;
      if ({ack0, ack1, dp_en_in, dp_en_out, busy, dp_a, dp_b, dp_sw} !== {5'b10101, 4'd3, 4'd5, 1'b0}) begin
         nerr++;
         $display("FAIL single_issue: got %b required %b", {ack0, ack1, dp_en_in, dp_en_out, busy, dp_a, dp_b, dp_sw},
                  {5'b10101, 4'd3, 4'd5, 1'b0});
      end
      req0 = 1'b0;
      for (int w = 0; w < 2; w++) begin
         tick();
         nvec++;
         if ({ack0, dp_en_in, dp_en_out, rsp_valid} !== 4'b0010) begin
            nerr++;
            $display("FAIL single_wait%0d: got %b required 0010", w, {ack0, dp_en_in, dp_en_out, rsp_valid});
         end
      end
      tick();
      nvec++;
      if ({rsp_valid, rsp_id, rsp_data, done_cnt, dp_en_out} !== {1'b1, 1'b0, 8'h0F, 8'd1, 1'b0}) begin
         nerr++;
         $display("FAIL single_resp: got %h required %h", {rsp_valid, rsp_id, rsp_data, done_cnt, dp_en_out},
                  {1'b1, 1'b0, 8'h0F, 8'd1, 1'b0});
      end
      tick();
      nvec++;
      if ({rsp_valid, busy, rsp_data, dp_a, dp_b, dp_sw} !== {1'b0, 1'b0, 8'h0F, 4'd0, 4'd0, 1'b0}) begin
         nerr++;
         $display("FAIL single_idle: got %h required %h", {rsp_valid, busy, rsp_data, dp_a, dp_b, dp_sw},
                  {1'b0, 1'b0, 8'h0F, 4'd0, 4'd0, 1'b0});
      end
   endtask

   task automatic test_complement();
      req1 = 1'b1; a1 = 4'd15; b1 = 4'd15; comp1 = 1'b1;
      tick();
      nvec++;
      if ({ack0, ack1, dp_sw, dp_a, dp_b} !== {3'b011, 4'hF, 4'hF}) begin
         nerr++;
         $display("FAIL comp_issue: got %b required %b", {ack0, ack1, dp_sw, dp_a, dp_b}, {3'b011, 4'hF, 4'hF});
      end
      req1 = 1'b0;
      for (int w = 0; w < 2; w++) begin
         tick();
         nvec++;
         if ({dp_sw, dp_en_out} !== 2'b11) begin
            nerr++;
            $display("FAIL comp_wait%0d: got %b required 11", w, {dp_sw, dp_en_out});
         end
      end
      tick();
      nvec++;
      if ({rsp_valid, rsp_id, rsp_data, done_cnt} !== {1'b1, 1'b1, 8'h1E, 8'd2}) begin
         nerr++;
         $display("FAIL comp_resp: got %h required %h", {rsp_valid, rsp_id, rsp_data, done_cnt}, {1'b1, 1'b1, 8'h1E, 8'd2});
      end
      tick();
      nvec++;
      if (dp_sw !== 1'b0) begin
         nerr++;
         $display("FAIL comp_sw_idle: got %b required 0", dp_sw);
      end
   endtask

   task automatic test_contention();
      int         ng;
      int         t[4];
      logic [3:0] ids;
      logic       prev, wide;
      ng = 0; ids = 4'd0; prev = 1'b0; wide = 1'b0;
      res = 1'b1;
      req0 = 1'b1; req1 = 1'b1; a0 = 4'd1; b0 = 4'd2; a1 = 4'd3; b1 = 4'd4; comp0 = 1'b0; comp1 = 1'b0;
      tick();
      res = 1'b0;
      for (int c = 0; c < 60 && ng < 4; c++) begin
         tick();
         if (prev && (ack0 || ack1)) wide = 1'b1;
         prev = ack0 | ack1;
         if (ack0 || ack1) begin
            ids[ng] = ack1;
            t[ng]   = c;
            ng++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      nvec++;
      if (ng != 4) begin
         nerr++;
         $display("FAIL contention_grants: got %0d grants required 4", ng);
      end else begin
         nvec++;
         if (ids !== 4'b1010) begin
            nerr++;
            $display("FAIL contention_order: got id bits %b (op3..op0) required 1010", ids);
         end
         nvec++;
         if ((t[1] - t[0] != 5) || (t[2] - t[1] != 5) || (t[3] - t[2] != 5)) begin
            nerr++;
            $display("FAIL contention_spacing: got %0d,%0d,%0d required 5,5,5", t[1] - t[0], t[2] - t[1], t[3] - t[2]);
         end
      end
      nvec++;
      if (wide !== 1'b0) begin
         nerr++;
         $display("FAIL contention_ack_width: got multi-cycle ack=%b required 0", wide);
      end
      wait_idle();
   endtask

   task automatic test_reset_mid_wait();
      logic seen;
      seen = 1'b0;
      req0 = 1'b1; a0 = 4'd2; b0 = 4'd3; comp0 = 1'b0;
      tick();
      req0 = 1'b0;
      tick();
      tick();
      nvec++;
      if (dp_en_out !== 1'b1) begin
         nerr++;
         $display("FAIL midwait_in_wait: dp_en_out=%b required 1", dp_en_out);
      end
      res = 1'b1;
      tick();
      nvec++;
      if ({ack0, ack1, dp_a, dp_b, dp_en_in, dp_en_out, dp_sw, rsp_valid, rsp_id, rsp_data, busy, done_cnt} !== 32'd0) begin
         nerr++;
         $display("FAIL midwait_reset_outputs: got %h required 0",
                  {ack0, ack1, dp_a, dp_b, dp_en_in, dp_en_out, dp_sw, rsp_valid, rsp_id, rsp_data, busy, done_cnt});
      end
      res = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      nvec++;
      if (seen !== 1'b0) begin
         nerr++;
         $display("FAIL midwait_no_rsp: rsp_valid seen=%b required 0", seen);
      end
      req0 = 1'b1; req1 = 1'b1;
      tick();
      req0 = 1'b0; req1 = 1'b0;
      nvec++;
      if ({ack0, ack1} !== 2'b10) begin
         nerr++;
         $display("FAIL midwait_regrant: got ack0,ack1=%b required 10", {ack0, ack1});
      end
      wait_idle();
      nvec++;
      if ({rsp_data, done_cnt} !== {8'd6, 8'd1}) begin
         nerr++;
         $display("FAIL midwait_after_op: got %h required %h", {rsp_data, done_cnt}, {8'd6, 8'd1});
      end
   endtask

   task automatic test_dropped_request();
      req1 = 1'b1;
      #2;
      req1 = 1'b0;
      tick();
      tick();
      nvec++;
      if ({ack0, ack1, busy, dp_en_in} !== 4'b0000) begin
         nerr++;
         $display("FAIL dropped_req: got %b required 0000", {ack0, ack1, busy, dp_en_in});
      end
   endtask

   task automatic test_lat1();
      res = 1'b1;
      tick();
      res = 1'b0;
      tick();
      req0 = 1'b1; a0 = 4'd4; b0 = 4'd4; comp0 = 1'b0;
      tick();
      req0 = 1'b0;
      nvec++;
      if ({ack0_l1, dp_en_in_l1} !== 2'b11) begin
         nerr++;
         $display("FAIL lat1_issue: got %b required 11", {ack0_l1, dp_en_in_l1});
      end
      tick();
      nvec++;
      if ({rsp_valid_l1, dp_en_out_l1} !== 2'b01) begin
         nerr++;
         $display("FAIL lat1_wait: got %b required 01", {rsp_valid_l1, dp_en_out_l1});
      end
      tick();
      nvec++;
      if ({rsp_valid_l1, rsp_id_l1, rsp_data_l1} !== {1'b1, 1'b0, 8'h10}) begin
         nerr++;
         $display("FAIL lat1_resp: got %h required %h", {rsp_valid_l1, rsp_id_l1, rsp_data_l1}, {1'b1, 1'b0, 8'h10});
      end
      wait_idle();
   endtask

   task automatic do_op();
      req0 = 1'b1;
      tick();
      req0 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_wrap();
      res = 1'b1;
      tick();
      res = 1'b0;
      tick();
      for (int n = 0; n < 255; n++) do_op();
      nvec++;
      if (done_cnt !== 8'd255) begin
         nerr++;
         $display("FAIL wrap_preload: done_cnt=%0d required 255", done_cnt);
      end
      do_op();
      nvec++;
      if (done_cnt !== 8'd0) begin
         nerr++;
         $display("FAIL wrap_zero: done_cnt=%0d required 0", done_cnt);
      end
   endtask

   initial begin
      res = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
      comp0 = 1'b0; comp1 = 1'b0;
      test_reset();
      test_single();
      test_complement();
      test_contention();
      test_reset_mid_wait();
      test_dropped_request();
      test_lat1();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dp_sched_ctrl.md
Name: dp_sched_ctrl

Overview:
- Two-channel scheduler sharing one multiply/complement datapath (4-bit operand pair in, 8-bit true or complement result out) between two requesters.
- Arbitrates round-robin, issues the operand pair with an input-enable pulse, and holds the output-enable and true/complement select while the result propagates.
- Captures the result after a fixed latency and returns it tagged with the requester ID.
- Sits between the client logic and the datapath top level; it is the only driver of the datapath inputs.

Parameters:
- LAT, 2, datapath cycles from the dp_en_in cycle to a valid dp_data (legal 1..15).
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- res  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from channel 0 / 1; held until ack.
- a0, b0 / a1, b1  in  4 each  operands for channel 0 / 1; stable while req is high.
- comp0 / comp1  in  1  1 = complement result requested, 0 = true result.
- ack0 / ack1  out  1  one-cycle grant pulse; operands latched.
- dp_a, dp_b  out  4 each  operands to the datapath.
- dp_en_in  out  1  datapath input enable; one-cycle pulse.
- dp_en_out  out  1  datapath output enable.
- dp_sw  out  1  datapath output select: 1 = complement, 0 = true.
- dp_data  in  8  datapath result.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  1  channel the result belongs to.
- rsp_data  out  8  captured result.
- busy  out  1  high whenever state != IDLE.
- done_cnt  out  CNT_W  completed operations; wraps at 2^CNT_W-1 -> 0.

Behaviour:
- Synchronous reset: all outputs 0, state = IDLE, wait counter = 0, last_id = 1 (channel 0 wins the first contention).
- Reset asserted mid-operation aborts the operation: no rsp_valid, the granted request is lost, done_cnt clears.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE at an edge where req0|req1 is sampled high.
  - Grant rule with one request: that channel.
  - Grant rule with both requests: the channel != last_id.
  - On grant: latch a, b, comp and id; set last_id = id.
- ISSUE (1 cycle):
  - ack[id] = 1.
  - dp_en_in = 1.
  - dp_a, dp_b and dp_sw driven from the latched values.
  - Load wait counter with LAT-1. Next state WAIT.
- WAIT (LAT cycles):
  - dp_en_out = 1; dp_sw and dp_a/dp_b held; dp_en_in = 0.
  - Counter decrements each cycle.
  - At the edge where counter == 0: rsp_data <= dp_data; next state RESP.
- RESP (1 cycle):
  - rsp_valid = 1, rsp_id = latched id, rsp_data stable.
  - done_cnt increments. dp_en_out = 0.
  - Next state IDLE.
- rsp_data and rsp_id hold their values after RESP until the next capture. rsp_valid is a pulse only.
- Latency and throughput:
  - Request sampled at edge E -> ack and dp_en_in in cycle E+1.
  - rsp_valid in cycle E+LAT+2.
  - Earliest next grant is sampled at the end of the first IDLE cycle, so back-to-back operations start every LAT+3 cycles.
- Requests seen while not in IDLE are ignored; no queueing.
- A requester must drop req within LAT+1 cycles after its ack, otherwise the held req is treated as a new request.
- Request withdrawn before grant: no action, no error.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1.
- dp_a, dp_b and dp_sw return to 0 in IDLE.

Test Plan:
- Reset then a single request:
  - Stimulus: req0 with a0=3, b0=5, comp0=0, LAT=2. Bench datapath model returns a*b (or ~(a*b) when dp_sw=1) LAT cycles after dp_en_in.
  - Response: ack0 and dp_en_in in cycle E+1; dp_en_out high for 2 cycles; rsp_valid in cycle E+4 with rsp_id=0, rsp_data=0x0F; done_cnt=1.
- Complement path:
  - Stimulus: req1 with a1=15, b1=15, comp1=1.
  - Response: dp_sw=1 from ISSUE through WAIT; rsp_data=~0xE1=0x1E; rsp_id=1.
- Contention:
  - Stimulus: req0 and req1 held high together from reset for 4 operations.
  - Response: grant order 0,1,0,1; each ack is exactly one cycle; ops start 5 cycles apart.
- Reset mid-WAIT:
  - Stimulus: assert res during the second WAIT cycle.
  - Response: next cycle all outputs are 0, no rsp_valid, done_cnt=0, busy=0; a following request from channel 0 is granted (last_id=1).
- Boundaries:
  - LAT=1 build: rsp_valid in cycle E+3.
  - done_cnt preloaded by 255 operations: the 256th completion wraps it to 0.
  - Request dropped one cycle before the sampling edge: no ack, state remains IDLE.
